// File: rtl/fd_pipe_pkg.sv
// Shared constants and the parameter-legality check for the fd1p3_pipe register pipeline.
package fd_pipe_pkg;

    localparam int MAX_DEPTH = 16;
    localparam int MAX_WIDTH = 64;

    localparam string MODE_HOLD    = "HOLD";
    localparam string MODE_ELASTIC = "ELASTIC";

    localparam string GSR_ENABLED  = "ENABLED";
    localparam string GSR_DISABLED = "DISABLED";

    // True when the numeric ranges are supported and both string selectors were recognised.
    function automatic bit params_legal(
        input int width,
        input int depth,
        input bit mode_known,
        input bit gsr_known
    );
        return (width >= 1) && (width <= MAX_WIDTH) &&
               (depth >= 1) && (depth <= MAX_DEPTH) &&
               mode_known && gsr_known;
    endfunction

endpackage

// File: rtl/fd_pipe_stage.sv
// One pipeline stage: a WIDTH-bit data register plus its valid bit.
// The stage supports a clock enable, a synchronous set/reset to INIT, and an asynchronous reset.
// GSR_EN selects whether the asynchronous reset also restores the data to INIT.
module fd_pipe_stage #(
    parameter int              WIDTH  = 8,
    parameter logic [WIDTH-1:0] INIT  = '0,
    parameter bit              GSR_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sp,
    input  logic             lsr,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    input  logic             dv,
    output logic [WIDTH-1:0] q,
    output logic             qv
);

    logic [WIDTH-1:0] data_reg;
    logic             valid_reg;

    // The valid bit is always cleared asynchronously.
    // A load copies the incoming valid; LSR clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_reg <= 1'b0;
        end else if (sp) begin
            if (lsr) begin
                valid_reg <= 1'b0;
            end else if (load) begin
                valid_reg <= dv;
            end
        end
    end

    generate
        if (GSR_EN) begin : g_gsr
            // The data register returns to INIT on the asynchronous reset.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    data_reg <= INIT;
                end else if (sp) begin
                    if (lsr) begin
                        data_reg <= INIT;
                    end else if (load) begin
                        data_reg <= d;
                    end
                end
            end
        end else begin : g_no_gsr
            // The data register keeps its contents while reset is held.
            // Edges that arrive during reset are simply ignored.
            always_ff @(posedge clk) begin
                if (rst_n && sp) begin
                    if (lsr) begin
                        data_reg <= INIT;
                    end else if (load) begin
                        data_reg <= d;
                    end
                end
            end
        end
    endgenerate

    assign q  = data_reg;
    assign qv = valid_reg;

endmodule

// File: rtl/fd1p3_pipe.sv
// Clock-enabled register pipeline of DEPTH stages, each carrying WIDTH data bits and a valid bit.
// HOLD mode behaves as a lockstep delay line.
// ELASTIC mode is a bubble-collapsing valid/ready pipe, with the take chain kept in this module.
module fd1p3_pipe
    import fd_pipe_pkg::*;
#(
    parameter int               WIDTH = 8,
    parameter int               DEPTH = 4,
    parameter logic [WIDTH-1:0] INIT  = '0,
    parameter string            GSR   = "ENABLED",
    parameter string            MODE  = "HOLD"
) (
    input  logic             CK,
    input  logic             GSRN,
    input  logic             SP,
    input  logic             LSR,
    input  logic [WIDTH-1:0] D,
    input  logic             DV,
    output logic             DR,
    output logic [WIDTH-1:0] Q,
    output logic             QV,
    input  logic             QR
);

    localparam bit IS_ELASTIC = (MODE == MODE_ELASTIC);
    localparam bit MODE_KNOWN = IS_ELASTIC || (MODE == MODE_HOLD);
    localparam bit GSR_EN     = (GSR == GSR_ENABLED);
    localparam bit GSR_KNOWN  = GSR_EN || (GSR == GSR_DISABLED);

    generate
        if (!params_legal(WIDTH, DEPTH, MODE_KNOWN, GSR_KNOWN)) begin : g_bad_params
            $error("fd1p3_pipe: WIDTH/DEPTH out of range or unknown MODE/GSR");
        end
    endgenerate

    logic [WIDTH-1:0] stage_data [DEPTH];
    logic [DEPTH-1:0] stage_valid;
    logic [DEPTH-1:0] take;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_stage
            logic [WIDTH-1:0] src_data;
            logic             src_valid;

            // take_i = !v_i | take_{i+1}, with take_DEPTH = QR.
            // Unrolled, this is QR, or any empty stage at or after i.
            // Written this way, the chain never feeds back on its own vector.
            // HOLD mode shifts on every enabled edge.
            assign take[gi] = !IS_ELASTIC || QR || !(&stage_valid[DEPTH-1:gi]);

            if (gi == 0) begin : g_head
                assign src_data  = D;
                assign src_valid = DV;
            end else begin : g_body
                assign src_data  = stage_data[gi-1];
                assign src_valid = stage_valid[gi-1];
            end

            fd_pipe_stage #(
                .WIDTH  (WIDTH),
                .INIT   (INIT),
                .GSR_EN (GSR_EN)
            ) u_stage (
                .clk   (CK),
                .rst_n (GSRN),
                .sp    (SP),
                .lsr   (LSR),
                .load  (take[gi]),
                .d     (src_data),
                .dv    (src_valid),
                .q     (stage_data[gi]),
                .qv    (stage_valid[gi])
            );
        end
    endgenerate

    // In ELASTIC mode, ready depends combinationally on QR through the take chain; there is no skid buffer.
    assign DR = IS_ELASTIC ? (take[0] & SP) : SP;
    assign Q  = stage_data[DEPTH-1];
    assign QV = stage_valid[DEPTH-1];

endmodule
